// File: rtl/ldst_pkg.sv
// Shared definitions for the load/store sequencer: state encoding,
// operation codes and default datapath widths.
package ldst_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int OFF_W_DEF  = 4;
  localparam int CNT_W_DEF  = 8;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/controle_ldst_contador.sv
// Completed-operation counter: wraps modulo 2^CNT_W, synchronous
// active-low clear, advances only when inc is high.
module contador_ops #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/controle_ldst.sv
// Load/store sequencer: computes base+offs on the external adder, then moves
// one word memory->register (load) or register->memory (store).
module controle_ldst
  import ldst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OFF_W  = OFF_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [OFF_W-1:0]  base,
  input  logic [OFF_W-1:0]  offs,
  input  logic [ADDR_W-1:0] reg_idx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  op_count,
  output logic [OFF_W-1:0]  add_a,
  output logic [OFF_W-1:0]  add_b,
  input  logic [ADDR_W-1:0] add_soma,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_rw,
  output logic [ADDR_W-1:0] reg_ra,
  output logic [ADDR_W-1:0] reg_rb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_ads
);

  state_t              state;
  state_t              next_state;
  logic                op_q;
  logic [OFF_W-1:0]    base_q;
  logic [OFF_W-1:0]    offs_q;
  logic [ADDR_W-1:0]   reg_idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                count_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_LOAD;
      base_q    <= '0;
      offs_q    <= '0;
      reg_idx_q <= '0;
      addr_q    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        op_q      <= op;
        base_q    <= base;
        offs_q    <= offs;
        reg_idx_q <= reg_idx;
      end
      if (state == CALC) begin
        addr_q <= add_soma;
      end
    end
  end

  // Write enables are also gated by rst_n so a reset edge never commits a write.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    add_a      = '0;
    add_b      = '0;
    reg_we     = 1'b0;
    reg_rw     = '0;
    reg_ra     = '0;
    mem_we     = 1'b0;
    mem_ads    = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = CALC;
        end
      end
      CALC: begin
        add_a      = base_q;
        add_b      = offs_q;
        next_state = MEM;
      end
      MEM: begin
        mem_ads = addr_q;
        reg_ra  = reg_idx_q;
        if (op_q == OP_STORE) begin
          mem_we     = rst_n;
          next_state = DONE;
        end else begin
          next_state = WB;
        end
      end
      WB: begin
        mem_ads    = addr_q;
        reg_we     = rst_n;
        reg_rw     = reg_idx_q;
        next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  assign reg_rb    = '0;
  assign count_inc = (state == DONE);

  contador_ops #(
    .CNT_W (CNT_W)
  ) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (count_inc),
    .count (op_count)
  );

endmodule

// File: doc/controle_ldst.md
# controle_ldst

Load/store sequencer between the 4-bit address adder (`somador`), the 32×64 register file (`registrador`) and the 32×64 data memory (`memoria`). It accepts one command at a time, computes the memory address with the adder, and then does one of two transfers: a load (memory → register) or a store (register → memory). It drives every enable and index on those three blocks and reports completion and a count of completed operations.

## Interface
Parameters:
- `ADDR_W`, 5, memory/register index width (adder sum width)
- `OFF_W`, 4, adder operand width
- `CNT_W`, 8, completed-operation counter width

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset (sampled on `clk` rising edge)
- `start`  in  1  command request; sampled only in IDLE
- `op`  in  1  0 = load, 1 = store
- `base`  in  OFF_W  adder operand A
- `offs`  in  OFF_W  adder operand B
- `reg_idx`  in  ADDR_W  destination register (load) or source register (store)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in DONE
- `op_count`  out  CNT_W  completed operations, wraps modulo 2^CNT_W
- `add_a`, `add_b`  out  OFF_W  to adder `a`/`b`
- `add_soma`  in  ADDR_W  from adder `soma`
- `reg_we`  out  1  register file write enable
- `reg_rw`  out  ADDR_W  register file write index
- `reg_ra`, `reg_rb`  out  ADDR_W  register file read indices (`reg_rb` is tied to 0)
- `mem_we`  out  1  memory write enable
- `mem_ads`  out  ADDR_W  memory address

The data paths are wired outside this block: memory `din` ← register `doutA`, and register `din` ← memory `dout`.

## Operation
- The FSM has five states: IDLE, CALC, MEM, WB, DONE.
- **IDLE**
  - When `start=1`, latch `op`, `base`, `offs` and `reg_idx`, then go to CALC.
  - Otherwise stay in IDLE.
- **CALC**
  - Drive `add_a`/`add_b` from the latched operands.
  - Register `add_soma` into `addr_q`.
  - Go to MEM.
- **MEM**
  - Drive `mem_ads=addr_q` and `reg_ra=reg_idx_q`.
  - Store: `mem_we=1` → DONE.
  - Load: `mem_we=0` → WB.
- **WB** (load only)
  - Hold `mem_ads=addr_q`.
  - Drive `reg_we=1` and `reg_rw=reg_idx_q`.
  - Go to DONE.
- **DONE**
  - `done=1`; `op_count` increments at the end of this cycle.
  - Go to IDLE.
  - A new command can be accepted in the cycle that follows DONE.
- Address arithmetic:
  - `addr = base + offs`, a 5-bit unsigned result.
  - Range is 0..30, so it never overflows and never wraps.
- Command handling:
  - `start` is ignored while `busy=1`; no queueing.
  - `op`, `base`, `offs` and `reg_idx` are don't-care outside the IDLE sampling cycle.
- Outputs while idle: all enables are 0 in every state other than the one listed above. Indices read 0 when unused.

## Timing
- Command accepted at edge T0 (IDLE, `start=1`).
- Store sequence:
  - CALC in cycle T0..T1.
  - MEM in T1..T2; the memory write happens at edge T2.
  - DONE in T2..T3.
  - Latency: 3 cycles from accept to `done`.
- Load sequence:
  - CALC, then MEM (memory read registered at edge T2).
  - WB in T2..T3; the register write happens at edge T3.
  - DONE in T3..T4.
  - Latency: 4 cycles.
- Read-latency assumptions:
  - Memory read latency is 1 cycle (synchronous).
  - Register file read is combinational.
- Reset values (`rst_n=0` at an edge):
  - state=IDLE, latched operands=0, `addr_q=0`, `op_count=0`.
  - `busy=0`, `done=0`, all enables 0, all indices 0.
- Reset during operation:
  - While `rst_n=0`, `reg_we` and `mem_we` are gated to 0 combinationally, so no write can commit on the reset edge.
  - An aborted operation does not increment `op_count`.
- `start=1` together with `rst_n=0`: reset wins, and the command is dropped.
- `op_count` wraps from 255 to 0.

## Structure
- Shared package `ldst_pkg`:
  - state encoding constants (IDLE=0, CALC=1, MEM=2, WB=3, DONE=4; 3-bit)
  - `OP_LOAD=0`, `OP_STORE=1`
  - `ADDR_W`, `OFF_W` defaults
- The FSM and its output decode stay inline.
- One natural sub-module: `contador_ops` (the wrapping counter with synchronous active-low reset and an increment enable).

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles while `start=1` → `busy=0`, `done=0`, `op_count=0`, no enable ever high.
- **Store:** R3 preloaded with 64'hDEAD_BEEF_0123_4567; command `op=1`, `base=2`, `offs=5`, `reg_idx=3` → `mem_we=1` with `mem_ads=7` exactly one cycle; `done` 3 cycles after accept; memory[7] reads back the same value; `op_count=1`.
- **Load:** memory[30] = 64'h1; command `op=0`, `base=15`, `offs=15`, `reg_idx=9` → `reg_we=1` with `reg_rw=9` exactly one cycle; R9=64'h1; `done` 4 cycles after accept.
- **Busy rejection:** pulse `start` in each of CALC/MEM/WB with different operands → ignored, and only the first command executes.
- **Mid-op reset:** assert `rst_n=0` in MEM of a store → no memory write; state IDLE next cycle; `op_count` unchanged.
- **Back-to-back wrap:** 256 consecutive stores, each restarted the cycle after `done` → `op_count` returns to 0; each command is accepted with a 1-cycle IDLE gap.
